// File: rtl/as6501_stop_rx.sv
// AS6501 stop-result receiver: deserializes TDC words, applies time/gc offsets,
// gates the stop time against two windows and emits one AXI-Stream beat per word.
module as6501_stop_rx #(
  parameter int GC_W   = 48,
  parameter int DATA_W = 128
) (
  input  logic              lclk_i,
  input  logic              arstn,
  input  logic              sr_enable,
  input  logic [15:0]       sr_index_stop_bitwise_i,
  input  logic [15:0]       sr_shift_tdc_time_i,
  input  logic [15:0]       sr_shift_gc_back_i,
  input  logic [31:0]       sr_gate0_i,
  input  logic [31:0]       sr_gate1_i,
  input  logic              sr_start_gc_i,
  input  logic              gc_rst,
  input  logic              sr_command_count,
  input  logic              frame_i,
  input  logic              sdi_i,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic [3:0]        m_axis_tuser,
  input  logic              m_axis_tready,
  output logic [1:0]        click_result,
  output logic [GC_W-1:0]   gc,
  output logic [15:0]       total_count,
  output logic              overflow
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t            r_state, w_next;
  logic              r_f, r_f_d, r_d;
  logic [31:0]       r_word;
  logic [4:0]        r_cnt;
  logic [7:0]        r_stop_bits;
  logic [GC_W-1:0]   r_gc_cap, r_gc;
  logic              r_tvalid, r_overflow, r_cmd_d;
  logic [DATA_W-1:0] r_tdata;
  logic [1:0]        r_click;
  logic [15:0]       r_total;

  logic              w_frame_edge, w_start, w_shift;
  logic [8:0]        w_n_raw;
  logic [5:0]        w_n;
  logic [4:0]        w_cnt_init;
  logic [31:0]       w_stop_mask;
  logic [15:0]       w_stop_t;
  logic [3:0]        w_index;
  logic [GC_W-1:0]   w_gc_t;
  logic [1:0]        w_click;
  logic [DATA_W-1:0] w_beat;
  logic              w_res_valid, w_load;

  // Pin synchronisers; the edge detector looks at the registered copy only.
  always_ff @(posedge lclk_i or negedge arstn) begin
    if (!arstn) begin
      r_f   <= 1'b0;
      r_f_d <= 1'b0;
      r_d   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      r_f   <= frame_i;
      r_f_d <= r_f;
      r_d   <= sdi_i;
    end
  end

  assign w_frame_edge = r_f & ~r_f_d;
  assign w_n_raw      = {1'b0, sr_index_stop_bitwise_i[7:0]} + {1'b0, sr_index_stop_bitwise_i[15:8]};
  assign w_n          = (w_n_raw == 9'd0) ? 6'd1 : (w_n_raw > 9'd32) ? 6'd32 : w_n_raw[5:0];
  assign w_cnt_init   = 5'(w_n - 6'd1);

  always_ff @(posedge lclk_i or negedge arstn) begin
    if (!arstn) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_next  = r_state;
    w_start = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      S_SHIFT: begin
        if (!sr_enable) begin
          w_next = S_IDLE;
        end else if (w_frame_edge) begin
          w_start = 1'b1;
          w_next  = (w_cnt_init == 5'd0) ? S_DONE : S_SHIFT;
        end else begin
          w_shift = 1'b1;
          if (r_cnt == 5'd1) w_next = S_DONE;
        end
      end
      default: begin
        // DONE lasts one cycle but may accept a new word edge like IDLE.
        w_next = S_IDLE;
        if (w_frame_edge && sr_enable) begin
          w_start = 1'b1;
          w_next  = (w_cnt_init == 5'd0) ? S_DONE : S_SHIFT;
        end
      end
    endcase
  end

  always_ff @(posedge lclk_i or negedge arstn) begin
    if (!arstn) begin
      r_word      <= '0;
      r_cnt       <= '0;
      r_stop_bits <= '0;
      r_gc_cap    <= '0;
    end else if (w_start) begin
      r_word      <= {31'd0, r_d};
      r_cnt       <= w_cnt_init;
      r_stop_bits <= sr_index_stop_bitwise_i[15:8];
      r_gc_cap    <= r_gc;
    end else if (w_shift) begin
      r_word <= {r_word[30:0], r_d};
      r_cnt  <= r_cnt - 5'd1;
    end
  end

  // Field split and offsets, evaluated while the FSM sits in DONE.
  assign w_stop_mask = (r_stop_bits >= 8'd32) ? '1 : ((32'd1 << r_stop_bits) - 32'd1);
  assign w_stop_t    = 16'(r_word & w_stop_mask) - sr_shift_tdc_time_i;
  assign w_index     = 4'(r_word >> r_stop_bits);
  assign w_gc_t      = r_gc_cap - GC_W'(sr_shift_gc_back_i);
  assign w_click[0]  = (sr_gate0_i[15:0] <= w_stop_t) && (w_stop_t < sr_gate0_i[31:16]);
  assign w_click[1]  = (sr_gate1_i[15:0] <= w_stop_t) && (w_stop_t < sr_gate1_i[31:16]);

  always_comb begin
    w_beat             = '0;
    w_beat[31:0]       = r_word;
    w_beat[47:32]      = w_stop_t;
    w_beat[48 +: GC_W] = w_gc_t;
    w_beat[99:96]      = w_index;
    w_beat[101:100]    = w_click;
  end

  assign w_res_valid = (r_state == S_DONE);
  assign w_load      = w_res_valid && (!r_tvalid || m_axis_tready);

  always_ff @(posedge lclk_i or negedge arstn) begin
    if (!arstn) begin
      r_tvalid   <= 1'b0;
      // NOTE: the wide data register is reset too, since the bus must read 0 out of reset.
      r_tdata    <= '0;
      r_click    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_load) begin
        r_tvalid <= 1'b1;
        r_tdata  <= w_beat;
        r_click  <= w_click;
      end else if (m_axis_tready) begin
        r_tvalid <= 1'b0;
      end
      if (w_res_valid && r_tvalid && !m_axis_tready) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge lclk_i or negedge arstn) begin
    if (!arstn)             r_gc <= '0;
    else if (gc_rst)        r_gc <= '0;
    else if (sr_start_gc_i) r_gc <= r_gc + GC_W'(1);
  end

  always_ff @(posedge lclk_i or negedge arstn) begin
    if (!arstn) begin
      r_cmd_d <= 1'b0;
      r_total <= '0;
    end else begin
      r_cmd_d <= sr_command_count;
      if (sr_command_count && !r_cmd_d)
        r_total <= '0;
      else if (sr_command_count && w_load && (r_total != 16'hFFFF))
        r_total <= r_total + 16'd1;
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tuser  = {2'b00, r_click};
  assign click_result  = r_click;
  assign gc            = r_gc;
  assign total_count   = r_total;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_as6501_stop_rx.sv
// Bench for as6501_stop_rx: directed scenarios plus randomized words, all beats
// compared against an arithmetic reference model through a scoreboard queue.
module tb_as6501_stop_rx;

  logic         clk = 1'b0;
  logic         arstn;
  logic         sr_enable;
  logic [15:0]  sr_index_stop_bitwise_i, sr_shift_tdc_time_i, sr_shift_gc_back_i;
  logic [31:0]  sr_gate0_i, sr_gate1_i;
  logic         sr_start_gc_i, gc_rst, sr_command_count, frame_i, sdi_i;
  logic [127:0] m_axis_tdata;
  logic         m_axis_tvalid, m_axis_tready;
  logic [3:0]   m_axis_tuser;
  logic [1:0]   click_result;
  logic [47:0]  gc;
  logic [15:0]  total_count;
  logic         overflow;

  int total = 0;
  int bad   = 0;
  bit rand_ready  = 1'b0;
  bit fixed_ready = 1'b1;

  typedef struct {
    logic [127:0] data;
    logic [1:0]   click;
  } beat_t;
  beat_t exp_q[$];

  logic [47:0] m_gc;

  always #5 clk = ~clk;

  as6501_stop_rx dut (
    .lclk_i                  (clk),
    .arstn                   (arstn),
    .sr_enable               (sr_enable),
    .sr_index_stop_bitwise_i (sr_index_stop_bitwise_i),
    .sr_shift_tdc_time_i     (sr_shift_tdc_time_i),
    .sr_shift_gc_back_i      (sr_shift_gc_back_i),
    .sr_gate0_i              (sr_gate0_i),
    .sr_gate1_i              (sr_gate1_i),
    .sr_start_gc_i           (sr_start_gc_i),
    .gc_rst                  (gc_rst),
    .sr_command_count        (sr_command_count),
    .frame_i                 (frame_i),
    .sdi_i                   (sdi_i),
    .m_axis_tdata            (m_axis_tdata),
    .m_axis_tvalid           (m_axis_tvalid),
    .m_axis_tuser            (m_axis_tuser),
    .m_axis_tready           (m_axis_tready),
    .click_result            (click_result),
    .gc                      (gc),
    .total_count             (total_count),
    .overflow                (overflow)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference global counter, following the counting rules directly.
  always @(posedge clk or negedge arstn) begin
    if (!arstn)             m_gc <= '0;
    else if (gc_rst)        m_gc <= '0;
    else if (sr_start_gc_i) m_gc <= m_gc + 48'd1;
  end

  function automatic beat_t model(input int sb, input logic [31:0] w, input logic [47:0] gce);
    beat_t b;
    longint unsigned wl, stop, idx, st, gct, g0lo, g0hi, g1lo, g1hi;
    wl = w;
    if (sb >= 32) begin
      stop = wl;
      idx  = 0;
    end else begin
      stop = wl % (64'd1 << sb);
      idx  = wl / (64'd1 << sb);
    end
    st   = ((stop % 65536) + 65536 - sr_shift_tdc_time_i) % 65536;
    gct  = (gce + (64'd1 << 48) - sr_shift_gc_back_i) % (64'd1 << 48);
    g0lo = sr_gate0_i[15:0];  g0hi = sr_gate0_i[31:16];
    g1lo = sr_gate1_i[15:0];  g1hi = sr_gate1_i[31:16];
    b.click = {(st >= g1lo) && (st < g1hi), (st >= g0lo) && (st < g0hi)};
    b.data  = {26'd0, b.click, 4'(idx % 16), 48'(gct), 16'(st), w};
    return b;
  endfunction

  // Single process owning tready: random in random mode, else the fixed level.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
    end
  end

  // Scoreboard: every accepted beat must match the oldest expected one.
  always @(negedge clk) begin
    if (arstn && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1'b1, 1'b0);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("tdata", m_axis_tdata, e.data);
        check("tuser", m_axis_tuser, {2'b00, e.click});
        check("click_result", click_result, e.click);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      frame_i = 1'b0;
      sdi_i   = 1'b0;
    end
  endtask

  task automatic send_word(input int ib, input int sb, input logic [31:0] raw, input bit expect_beat);
    int n;
    longint unsigned wl;
    logic [31:0] w;
    logic [47:0] gce;
    n = ib + sb;
    if (n < 1)  n = 1;
    if (n > 32) n = 32;
    wl = raw;
    if (n < 32) wl = wl % (64'd1 << n);
    w   = wl[31:0];
    gce = '0;
    @(posedge clk); #1;
    sr_index_stop_bitwise_i = {8'(sb), 8'(ib)};
    frame_i = 1'b1;
    sdi_i   = w[n-1];
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      if (i == 1) gce = m_gc;
      frame_i = 1'b0;
      sdi_i   = (i < n) ? w[n-1-i] : 1'b0;
    end
    if (expect_beat) exp_q.push_back(model(sb, w, gce));
  endtask

  // Starts a word but stops driving after nbits (nbits >= 2).
  task automatic partial(input int ib, input int sb, input logic [31:0] raw, input int nbits);
    @(posedge clk); #1;
    sr_index_stop_bitwise_i = {8'(sb), 8'(ib)};
    frame_i = 1'b1;
    sdi_i   = raw[31];
    for (int i = 1; i < nbits; i++) begin
      @(posedge clk); #1;
      frame_i = 1'b0;
      sdi_i   = raw[31-i];
    end
  endtask

  task automatic wait_drain(input string tag);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 300) begin
      @(posedge clk); #2;
      cyc++;
    end
    check(tag, 128'(exp_q.size()), 128'd0);
    idle(2);
  endtask

  // Sends index/stop with 4+14 bit fields and checks latency plus decoded fields.
  task automatic directed(input int idx, input int stop, input logic [15:0] exp_st,
                          input logic [1:0] exp_click, input string tag);
    send_word(4, 14, 32'((idx << 14) | stop), 1'b1);
    @(posedge clk); @(negedge clk);
    check({tag, "_lat_early"}, m_axis_tvalid, 1'b0);
    @(posedge clk); @(negedge clk);
    check({tag, "_lat_valid"}, m_axis_tvalid, 1'b1);
    check({tag, "_stop_t"}, m_axis_tdata[47:32], exp_st);
    check({tag, "_click"}, m_axis_tdata[101:100], exp_click);
    check({tag, "_tuser"}, m_axis_tuser, {2'b00, exp_click});
    check({tag, "_index"}, m_axis_tdata[99:96], 4'(idx));
    wait_drain({tag, "_drain"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    arstn = 1'b0;
    sr_enable = 1'b1;
    sr_index_stop_bitwise_i = 16'h0E04;
    sr_shift_tdc_time_i = '0;
    sr_shift_gc_back_i  = '0;
    sr_gate0_i = 32'hFF00_0064;
    sr_gate1_i = 32'hFFF0_FF80;
    sr_start_gc_i = 1'b0;
    gc_rst = 1'b0;
    sr_command_count = 1'b0;
    frame_i = 1'b0;
    sdi_i   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tdata", m_axis_tdata, 128'd0);
    check("rst_tuser", m_axis_tuser, 4'd0);
    check("rst_gc", gc, 48'd0);
    check("rst_total", total_count, 16'd0);
    check("rst_overflow", overflow, 1'b0);
    @(posedge clk); #1;
    arstn = 1'b1;
    sr_start_gc_i = 1'b1;
    idle(3);

    // Basic word, offset miss, offset wrap (wrapped value lands in gate1).
    directed(3, 150, 16'd150, 2'b01, "basic");
    sr_shift_tdc_time_i = 16'd60;
    directed(3, 150, 16'd90, 2'b00, "miss");
    sr_shift_tdc_time_i = 16'd200;
    directed(3, 150, 16'hFFCE, 2'b10, "wrap");
    sr_shift_tdc_time_i = 16'd0;

    // Backpressure: first beat held, second dropped.
    fixed_ready = 1'b0;
    idle(3);
    send_word(4, 14, 32'((3 << 14) | 150), 1'b1);
    idle(4);
    send_word(4, 14, 32'((5 << 14) | 200), 1'b0);
    idle(6);
    @(negedge clk);
    check("bp_held_valid", m_axis_tvalid, 1'b1);
    check("bp_held_word", m_axis_tdata[31:0], 32'((3 << 14) | 150));
    check("bp_overflow", overflow, 1'b1);
    fixed_ready = 1'b1;
    wait_drain("bp_drain");
    @(negedge clk);
    check("bp_valid_drop", m_axis_tvalid, 1'b0);
    check("bp_overflow_sticky", overflow, 1'b1);

    // Global counter run, synchronous clear, and timestamp offset.
    idle(1000);
    @(negedge clk);
    check("gc_run", gc, m_gc);
    @(posedge clk); #1; gc_rst = 1'b1;
    @(posedge clk); #1; gc_rst = 1'b0;
    @(negedge clk);
    check("gc_clear", gc, 48'd0);
    sr_shift_gc_back_i = 16'd5;
    send_word(4, 14, 32'((7 << 14) | 300), 1'b1);
    wait_drain("gc_back_drain");
    gc_rst = 1'b1;
    send_word(4, 14, 32'((1 << 14) | 120), 1'b1);
    gc_rst = 1'b0;
    wait_drain("gc_wrap_drain");
    sr_shift_gc_back_i = 16'd0;

    // Counting window.
    @(posedge clk); #1; sr_command_count = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_word(4, 14, 32'((i << 14) | 400), 1'b1);
      wait_drain("cnt_drain");
    end
    @(negedge clk);
    check("count_three", total_count, 16'd3);
    @(posedge clk); #1; sr_command_count = 1'b0;
    idle(2);
    sr_command_count = 1'b1;
    idle(2);
    @(negedge clk);
    check("count_rearm", total_count, 16'd0);
    sr_command_count = 1'b0;

    // Disable mid-word discards it; a new frame mid-word restarts it.
    partial(4, 14, $urandom, 5);
    sr_enable = 1'b0;
    idle(25);
    sr_enable = 1'b1;
    idle(3);
    @(negedge clk);
    check("disable_no_beat", m_axis_tvalid, 1'b0);
    partial(4, 14, $urandom, 6);
    send_word(4, 14, 32'((9 << 14) | 777), 1'b1);
    wait_drain("abort_drain");

    // Reset mid-word.
    partial(4, 14, $urandom, 5);
    arstn = 1'b0;
    #1;
    check("mid_rst_tvalid", m_axis_tvalid, 1'b0);
    check("mid_rst_tdata", m_axis_tdata, 128'd0);
    check("mid_rst_overflow", overflow, 1'b0);
    check("mid_rst_click", click_result, 2'd0);
    check("mid_rst_gc", gc, 48'd0);
    idle(2);
    arstn = 1'b1;
    idle(30);
    @(negedge clk);
    check("post_rst_no_beat", m_axis_tvalid, 1'b0);

    // Randomized words, offsets, gates and tready.
    rand_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      int ib, sb;
      ib = $urandom_range(0, 12);
      sb = $urandom_range(0, 20);
      if ($urandom_range(0, 7) == 0) begin
        ib = $urandom_range(0, 255);
        sb = $urandom_range(0, 255);
      end
      sr_shift_tdc_time_i = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'd0;
      sr_shift_gc_back_i  = 16'($urandom);
      sr_gate0_i = {16'($urandom), 16'($urandom_range(0, 1) == 0 ? 0 : $urandom)};
      sr_gate1_i = {16'($urandom), 16'($urandom)};
      send_word(ib, sb, $urandom, 1'b1);
      wait_drain("rand_drain");
    end
    rand_ready = 1'b0;
    idle(2);
    @(negedge clk);
    check("final_overflow", overflow, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
